// File: rtl/minmax_pkg.sv
// Shared types and constants for the minmax_reduce streaming min/max unit.
package minmax_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } minmax_state_e;

    localparam logic MINMAX_OP_MIN = 1'b0;
    localparam logic MINMAX_OP_MAX = 1'b1;

endpackage

// File: rtl/minmax_cmp.sv
// Strict "a beats b" compare for min/max, signed or unsigned.
module minmax_cmp
    import minmax_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op_max,
    input  logic             op_signed,
    output logic             take_a
);

    logic [WIDTH-1:0] a_key;
    logic [WIDTH-1:0] b_key;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    always_comb begin
        a_key = a;
        b_key = b;
        if (op_signed) begin
            a_key[WIDTH-1] = ~a[WIDTH-1];
            b_key[WIDTH-1] = ~b[WIDTH-1];
        end
        take_a = (op_max == MINMAX_OP_MAX) ? (a_key > b_key) : (a_key < b_key);
    end

endmodule

// File: rtl/minmax_reduce.sv
// Streaming min/max reduction over a valid/ready packet, one element per cycle.
// Define MINMAX_INDEX_EN to track and report the winning element's position.
//
// state | meaning
// IDLE  | no packet open, next beat starts a packet
// ACCUM | packet open, comparing each beat against best
// DONE  | result held on outputs until out_ready
module minmax_reduce
    import minmax_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             op_max,
    input  logic             op_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [IDX_W-1:0] out_index,
    output logic [IDX_W-1:0] out_count
);

    localparam logic [IDX_W-1:0] CNT_MAX = {IDX_W{1'b1}};

    minmax_state_e    state;
    minmax_state_e    state_next;
    logic [WIDTH-1:0] best;
    logic [IDX_W-1:0] cnt;
    logic             op_max_q;
    logic             op_signed_q;
    logic             beat;
    logic             take_a;

    assign in_ready  = (state != DONE);
    assign out_valid = (state == DONE);
    assign beat      = in_valid && in_ready;

    minmax_cmp #(.WIDTH(WIDTH)) u_cmp (
        .a         (in_data),
        .b         (best),
        .op_max    (op_max_q),
        .op_signed (op_signed_q),
        .take_a    (take_a)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE, ACCUM: begin
                if (beat) begin
                    state_next = in_last ? DONE : ACCUM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            best        <= '0;
            cnt         <= '0;
            op_max_q    <= MINMAX_OP_MIN;
            op_signed_q <= 1'b0;
        end else begin
            state <= state_next;
            if (beat) begin
                if (state == IDLE) begin
                    op_max_q    <= op_max;
                    op_signed_q <= op_signed;
                    best        <= in_data;
                    cnt         <= IDX_W'(1);
                end else begin
                    if (take_a) begin
                        best <= in_data;
                    end
                    // Saturate so oversized packets still reduce, just with clamped count.
                    if (cnt != CNT_MAX) begin
                        cnt <= cnt + IDX_W'(1);
                    end
                end
            end
        end
    end

`ifdef MINMAX_INDEX_EN
    logic [IDX_W-1:0] best_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            best_idx <= '0;
        end else if (beat) begin
            if (state == IDLE) begin
                best_idx <= '0;
            end else if (take_a) begin
                best_idx <= cnt;
            end
        end
    end

    assign out_index = best_idx;
`else
    assign out_index = '0;
`endif

    assign out_result = best;
    assign out_count  = cnt;

endmodule

// File: tb/tb_minmax_reduce.sv
// Directed self-checking bench for minmax_reduce (wide instance and IDX_W=2 instance).
module tb_minmax_reduce;

`ifdef MINMAX_INDEX_EN
    localparam bit IDX_EN = 1'b1;
`else
    localparam bit IDX_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_last, op_max, op_signed, out_ready;
    logic [31:0] in_data;
    logic        in_ready, out_valid;
    logic [31:0] out_result;
    logic [7:0]  out_index, out_count;

    logic        r_in_valid, r_in_last, r_out_ready;
    logic [7:0]  r_in_data;
    logic        r_in_ready, r_out_valid;
    logic [7:0]  r_out_result;
    logic [1:0]  r_out_index, r_out_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    minmax_reduce #(.WIDTH(32), .IDX_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .op_max(op_max), .op_signed(op_signed),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_index(out_index), .out_count(out_count)
    );

    minmax_reduce #(.WIDTH(8), .IDX_W(2)) dut_small (
        .clk(clk), .rst(rst), .in_valid(r_in_valid), .in_ready(r_in_ready),
        .in_data(r_in_data), .in_last(r_in_last), .op_max(1'b1), .op_signed(1'b0),
        .out_valid(r_out_valid), .out_ready(r_out_ready), .out_result(r_out_result),
        .out_index(r_out_index), .out_count(r_out_count)
    );

    function automatic logic [63:0] exp_idx(input int n);
        return IDX_EN ? 64'(n) : 64'd0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic beat(input logic [31:0] d, input logic l, input logic mx, input logic sg);
        chk("in_ready_before_beat", 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = l;
        op_max    = mx;
        op_signed = sg;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic result(input string tag, input logic [31:0] r, input int idx, input int cnt);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_ready_low"}, 64'(in_ready), 64'd0);
        chk({tag, "_result"}, 64'(out_result), 64'(r));
        chk({tag, "_index"}, 64'(out_index), exp_idx(idx));
        chk({tag, "_count"}, 64'(out_count), 64'(cnt));
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_valid_low", 64'(out_valid), 64'd0);
        chk("release_ready_high", 64'(in_ready), 64'd1);
    endtask

    task automatic r_beat(input logic [7:0] d, input logic l);
        r_in_valid = 1'b1;
        r_in_data  = d;
        r_in_last  = l;
        @(posedge clk); #1;
        r_in_valid = 1'b0;
        r_in_last  = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 0; in_last = 0; op_max = 0; op_signed = 0; out_ready = 0; in_data = '0;
        r_in_valid = 0; r_in_last = 0; r_out_ready = 0; r_in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(out_result), 64'd0);
        chk("rst_index", 64'(out_index), 64'd0);
        chk("rst_count", 64'(out_count), 64'd0);
        rst = 1'b0;

        // Unsigned max
        beat(32'd3, 0, 1, 0);
        beat(32'hFFFF_FFFF, 0, 1, 0);
        beat(32'd7, 1, 1, 0);
        result("umax", 32'hFFFF_FFFF, 1, 3);
        release_out();

        // Signed min, then same packet unsigned min
        beat(32'd5, 0, 0, 1);
        beat(32'hFFFF_FFFE, 0, 0, 1);
        beat(32'h8000_0000, 0, 0, 1);
        beat(32'd2, 1, 0, 1);
        result("smin", 32'h8000_0000, 2, 4);
        release_out();
        beat(32'd5, 0, 0, 0);
        beat(32'hFFFF_FFFE, 0, 0, 0);
        beat(32'h8000_0000, 0, 0, 0);
        beat(32'd2, 1, 0, 0);
        result("umin", 32'd2, 3, 4);
        release_out();

        // Tie keeps first occurrence
        beat(32'd9, 0, 1, 0);
        beat(32'd9, 0, 1, 0);
        beat(32'd4, 1, 1, 0);
        result("tie", 32'd9, 0, 3);
        release_out();

        // Single element with backpressure and ignored beats in DONE
        beat(32'h1234, 1, 0, 0);
        result("single", 32'h1234, 0, 1);
        in_valid = 1'b1; in_data = 32'h55; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            result("hold", 32'h1234, 0, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("hold_exit_valid", 64'(out_valid), 64'd0);
        chk("hold_exit_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        result("after_hold", 32'h55, 0, 1);
        release_out();

        // Mode flipped mid-packet is ignored
        beat(32'd10, 0, 0, 0);
        beat(32'd20, 0, 1, 1);
        beat(32'd5, 1, 1, 1);
        result("mode_flip", 32'd5, 2, 3);
        release_out();

        // Reset mid-packet
        beat(32'd7, 0, 1, 0);
        in_valid = 1'b1; in_data = 32'd3; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_ready", 64'(in_ready), 64'd1);
        chk("midrst_result", 64'(out_result), 64'd0);
        chk("midrst_count", 64'(out_count), 64'd0);
        beat(32'd100, 0, 0, 0);
        beat(32'd50, 1, 0, 0);
        result("post_rst", 32'd50, 1, 2);
        release_out();

        // Counter saturation with IDX_W = 2
        r_beat(8'd1, 0);
        r_beat(8'd2, 0);
        r_beat(8'd3, 0);
        r_beat(8'd4, 0);
        r_beat(8'd5, 0);
        r_beat(8'd9, 1);
        chk("sat_valid", 64'(r_out_valid), 64'd1);
        chk("sat_result", 64'(r_out_result), 64'd9);
        chk("sat_count", 64'(r_out_count), 64'd3);
        chk("sat_index", 64'(r_out_index), exp_idx(3));
        r_out_ready = 1'b1;
        @(posedge clk); #1;
        r_out_ready = 1'b0;
        chk("sat_release", 64'(r_out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
